dbus_arbiter: RTL and testbench

Data-bus controller between two bus masters (m0 = processor load/store port, m1 = debug/loader port) and the shared data resources: the synchronous data memory and the memory-mapped I/O registers (HEX, LEDR, LEDG, KEY, SW). It arbitrates one access per cycle, decodes the address, and owns the I/O output registers and the input synchronizers. It returns read data with fixed one-cycle latency.

---
 rtl/dbus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dbus_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbus_arbiter
// Description : Two-master data-bus arbiter with address decode to data memory
//               and memory-mapped I/O (HEX/LEDR/LEDG/KEY/SW); one-cycle reads.
//               Define ARB_ROUND_ROBIN_EN for alternating contention grants,
//               otherwise m0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_arbiter #(
    parameter int          DBITS          = 32,
    parameter int          DMEM_ADDR_BITS = 13,
    parameter logic [31:0] ADDR_HEX       = 32'hF000_0000,
    parameter logic [31:0] ADDR_LEDR      = 32'hF000_0004,
    parameter logic [31:0] ADDR_LEDG      = 32'hF000_0008,
    parameter logic [31:0] ADDR_KEY       = 32'hF000_0010,
    parameter logic [31:0] ADDR_SW        = 32'hF000_0014
) (
    input  logic                        CLOCK_50,
    input  logic                        FPGA_RESET_N,
    input  logic                        m0_req,
    input  logic                        m0_we,
    input  logic [DBITS-1:0]            m0_addr,
    input  logic [DBITS-1:0]            m0_wdata,
    output logic                        m0_gnt,
    output logic                        m0_rvalid,
    output logic [DBITS-1:0]            m0_rdata,
    input  logic                        m1_req,
    input  logic                        m1_we,
    input  logic [DBITS-1:0]            m1_addr,
    input  logic [DBITS-1:0]            m1_wdata,
    output logic                        m1_gnt,
    output logic                        m1_rvalid,
    output logic [DBITS-1:0]            m1_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [DMEM_ADDR_BITS-3:0]   mem_addr,
    output logic [DBITS-1:0]            mem_wdata,
    input  logic [DBITS-1:0]            mem_rdata,
    input  logic [9:0]                  SW,
    input  logic [3:0]                  KEY,
    output logic [15:0]                 hex_out,
    output logic [9:0]                  ledr_out,
    output logic [7:0]                  ledg_out
);

    logic [9:0]       r_sw_meta, r_sw_sync;
    logic [3:0]       r_key_meta, r_key_sync;
    logic             r_last_m1;
    logic [15:0]      r_hex;
    logic [9:0]       r_ledr;
    logic [7:0]       r_ledg;
    logic             r_rd_pend, r_rd_m1, r_rd_io;
    logic [DBITS-1:0] r_io_val, r_m0_rdata, r_m1_rdata;

    logic             w_m0_gnt, w_m1_gnt, w_xfer;
    logic             w_we;
    logic [DBITS-1:0] w_addr, w_wdata, w_io_rd, w_ret_data;
    logic             w_io, w_hit_hex, w_hit_ledr, w_hit_ledg, w_hit_key, w_hit_sw;
    logic             w_unused;

    always_comb begin
        w_m0_gnt = 1'b0;
        w_m1_gnt = 1'b0;
        if (FPGA_RESET_N) begin
            if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                w_m0_gnt = r_last_m1;
                w_m1_gnt = !r_last_m1;
`else
                w_m0_gnt = 1'b1;
`endif
            end else begin
                w_m0_gnt = m0_req;
                w_m1_gnt = m1_req;
            end
        end
    end

    assign w_xfer  = w_m0_gnt | w_m1_gnt;
    assign w_we    = w_m1_gnt ? m1_we    : m0_we;
    assign w_addr  = w_m1_gnt ? m1_addr  : m0_addr;
    assign w_wdata = w_m1_gnt ? m1_wdata : m0_wdata;

    // Byte-lane bits are ignored; the pointer is only consumed in round-robin builds
    assign w_unused = ^{w_addr[1:0], r_last_m1};

    assign w_io       = (w_addr[DBITS-1:DBITS-4] == 4'hF);
    assign w_hit_hex  = w_io && (w_addr[DBITS-1:2] == ADDR_HEX[DBITS-1:2]);
    assign w_hit_ledr = w_io && (w_addr[DBITS-1:2] == ADDR_LEDR[DBITS-1:2]);
    assign w_hit_ledg = w_io && (w_addr[DBITS-1:2] == ADDR_LEDG[DBITS-1:2]);
    assign w_hit_key  = w_io && (w_addr[DBITS-1:2] == ADDR_KEY[DBITS-1:2]);
    assign w_hit_sw   = w_io && (w_addr[DBITS-1:2] == ADDR_SW[DBITS-1:2]);

    always_comb begin
        w_io_rd = '0;
        if (w_hit_hex)  w_io_rd = {{(DBITS-16){1'b0}}, r_hex};
        if (w_hit_ledr) w_io_rd = {{(DBITS-10){1'b0}}, r_ledr};
        if (w_hit_ledg) w_io_rd = {{(DBITS-8){1'b0}},  r_ledg};
        if (w_hit_key)  w_io_rd = {{(DBITS-4){1'b0}},  r_key_sync};
        if (w_hit_sw)   w_io_rd = {{(DBITS-10){1'b0}}, r_sw_sync};
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign mem_en    = w_xfer && !w_io;
    assign mem_we    = mem_en && w_we;
    assign mem_addr  = w_addr[DMEM_ADDR_BITS-1:2];
    assign mem_wdata = w_wdata;

    // Memory data arrives combinationally in the return cycle, so it bypasses the hold registers
    assign w_ret_data = r_rd_io ? r_io_val : mem_rdata;
    assign m0_rvalid  = r_rd_pend && !r_rd_m1;
    assign m1_rvalid  = r_rd_pend &&  r_rd_m1;
    assign m0_rdata   = m0_rvalid ? w_ret_data : r_m0_rdata;
    assign m1_rdata   = m1_rvalid ? w_ret_data : r_m1_rdata;

    assign hex_out  = r_hex;
    assign ledr_out = r_ledr;
    assign ledg_out = r_ledg;

    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_key_meta <= 4'hF;
            r_key_sync <= 4'hF;
            r_last_m1  <= 1'b1;
            r_hex      <= '0;
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_m1    <= 1'b0;
            r_rd_io    <= 1'b0;
            r_io_val   <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= KEY;
            r_key_sync <= r_key_meta;
            if (w_xfer) r_last_m1 <= w_m1_gnt;
            if (w_xfer && w_we) begin
                if (w_hit_hex)  r_hex  <= w_wdata[15:0];
                if (w_hit_ledr) r_ledr <= w_wdata[9:0];
                if (w_hit_ledg) r_ledg <= w_wdata[7:0];
            end
            r_rd_pend <= w_xfer && !w_we;
            if (w_xfer && !w_we) begin
                r_rd_m1  <= w_m1_gnt;
                r_rd_io  <= w_io;
                r_io_val <= w_io_rd;
            end
            if (r_rd_pend) begin
                if (r_rd_m1) r_m1_rdata <= w_ret_data;
                else         r_m0_rdata <= w_ret_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_arbiter
// Description : Directed table-driven bench for dbus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbus_arbiter dut (
        .CLOCK_50(clk), .FPGA_RESET_N(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .SW(sw), .KEY(key),
        .hex_out(hex_out), .ledr_out(ledr_out), .ledg_out(ledg_out)
    );

    typedef struct {
        logic        m0_req; logic m0_we; logic [31:0] m0_addr; logic [31:0] m0_wdata;
        logic        m1_req; logic m1_we; logic [31:0] m1_addr; logic [31:0] m1_wdata;
        logic [31:0] mem_rdata;
        logic        e_m0_gnt; logic e_m1_gnt; logic e_mem_en; logic e_mem_we; logic [10:0] e_mem_addr;
        logic        e_m0_rvalid; logic [31:0] e_m0_rdata; logic e_m1_rvalid; logic [31:0] e_m1_rdata;
        logic [15:0] e_hex; logic [9:0] e_ledr; logic [7:0] e_ledg;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    initial begin
        logic exp_m0, exp_m1, prev_m0, prev_m1;

        //          m0: req we addr           wdata         m1: req we addr    wdata         mem_rdata      gnt0 gnt1 en we addr    rv0 rdata0     rv1 rdata1         hex      ledr     ledg
        vecs[0]  = '{1, 1, 32'hF000_0004, 32'h0000_03FF, 0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  0, 32'h0,      0, 32'h0,          16'h0,    10'h0,   8'h0};
        vecs[1]  = '{1, 0, 32'hF000_0004, 32'h0,         0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  0, 32'h0,      0, 32'h0,          16'h0,    10'h3FF, 8'h0};
        vecs[2]  = '{1, 0, 32'hF000_0014, 32'h0,         0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  1, 32'h3FF,    0, 32'h0,          16'h0,    10'h3FF, 8'h0};
        vecs[3]  = '{1, 0, 32'hF000_0010, 32'h0,         0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  1, 32'h2AA,    0, 32'h0,          16'h0,    10'h3FF, 8'h0};
        vecs[4]  = '{1, 0, 32'hF000_000C, 32'h0,         0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  1, 32'h5,      0, 32'h0,          16'h0,    10'h3FF, 8'h0};
        vecs[5]  = '{0, 0, 32'h0,         32'h0,         1, 1, 32'h100,   32'hDEAD_BEEF, 32'h0,         0, 1, 1, 1, 11'h40, 1, 32'h0,      0, 32'h0,          16'h0,    10'h3FF, 8'h0};
        vecs[6]  = '{0, 0, 32'h0,         32'h0,         1, 0, 32'h100,   32'h0,         32'h0,         0, 1, 1, 0, 11'h40, 0, 32'h0,      0, 32'h0,          16'h0,    10'h3FF, 8'h0};
        vecs[7]  = '{0, 0, 32'h0,         32'h0,         0, 0, 32'h0,     32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0, 11'h0,  0, 32'h0,      1, 32'hDEAD_BEEF,  16'h0,    10'h3FF, 8'h0};
        vecs[8]  = '{1, 1, 32'hF000_0000, 32'h0000_1234, 1, 0, 32'h200,   32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  0, 32'h0,      0, 32'hDEAD_BEEF,  16'h0,    10'h3FF, 8'h0};
        vecs[9]  = '{0, 0, 32'h0,         32'h0,         1, 0, 32'h200,   32'h0,         32'h0,         0, 1, 1, 0, 11'h80, 0, 32'h0,      0, 32'hDEAD_BEEF,  16'h1234, 10'h3FF, 8'h0};
        vecs[10] = '{0, 0, 32'h0,         32'h0,         0, 0, 32'h0,     32'h0,         32'hCAFE_F00D, 0, 0, 0, 0, 11'h0,  0, 32'h0,      1, 32'hCAFE_F00D,  16'h1234, 10'h3FF, 8'h0};
        vecs[11] = '{1, 1, 32'hF000_0008, 32'hABCD_01FF, 0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  0, 32'h0,      0, 32'hCAFE_F00D,  16'h1234, 10'h3FF, 8'h0};
        vecs[12] = '{1, 1, 32'hF000_0014, 32'hFFFF_FFFF, 0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  0, 32'h0,      0, 32'hCAFE_F00D,  16'h1234, 10'h3FF, 8'hFF};
        vecs[13] = '{1, 0, 32'hF000_0000, 32'h0,         0, 0, 32'h0,     32'h0,         32'h0,         1, 0, 0, 0, 11'h0,  0, 32'h0,      0, 32'hCAFE_F00D,  16'h1234, 10'h3FF, 8'hFF};
        vecs[14] = '{0, 0, 32'h0,         32'h0,         0, 0, 32'h0,     32'h0,         32'h0,         0, 0, 0, 0, 11'h0,  1, 32'h1234,   0, 32'hCAFE_F00D,  16'h1234, 10'h3FF, 8'hFF};

        // Reset held with both masters requesting
        rst_n = 1'b0; mem_rdata = '0; sw = 10'h2AA; key = 4'b0101;
        idle();
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst m0_gnt", {31'b0, m0_gnt}, 0);
        chk("rst m1_gnt", {31'b0, m1_gnt}, 0);
        chk("rst mem_en", {31'b0, mem_en}, 0);
        chk("rst m0_rvalid", {31'b0, m0_rvalid}, 0);
        chk("rst m1_rvalid", {31'b0, m1_rvalid}, 0);
        chk("rst m0_rdata", m0_rdata, 0);
        chk("rst hex", {16'b0, hex_out}, 0);
        chk("rst ledr", {22'b0, ledr_out}, 0);
        chk("rst ledg", {24'b0, ledg_out}, 0);
        idle();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we; m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
            m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we; m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
            mem_rdata = vecs[i].mem_rdata;
            @(negedge clk);
            chk($sformatf("v%0d m0_gnt", i), {31'b0, m0_gnt}, {31'b0, vecs[i].e_m0_gnt});
            chk($sformatf("v%0d m1_gnt", i), {31'b0, m1_gnt}, {31'b0, vecs[i].e_m1_gnt});
            chk($sformatf("v%0d mem_en", i), {31'b0, mem_en}, {31'b0, vecs[i].e_mem_en});
            chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_mem_we});
            if (vecs[i].e_mem_en) begin
                chk($sformatf("v%0d mem_addr", i), {21'b0, mem_addr}, {21'b0, vecs[i].e_mem_addr});
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_we ? vecs[i].m1_wdata | vecs[i].m0_wdata : mem_wdata);
            end
            chk($sformatf("v%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, vecs[i].e_m0_rvalid});
            chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].e_m0_rdata);
            chk($sformatf("v%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, vecs[i].e_m1_rvalid});
            chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].e_m1_rdata);
            chk($sformatf("v%0d hex", i), {16'b0, hex_out}, {16'b0, vecs[i].e_hex});
            chk($sformatf("v%0d ledr", i), {22'b0, ledr_out}, {22'b0, vecs[i].e_ledr});
            chk($sformatf("v%0d ledg", i), {24'b0, ledg_out}, {24'b0, vecs[i].e_ledg});
        end

        // Continuous contention on memory reads; last accepted transfer above was m0
        prev_m0 = 1'b0; prev_m1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            idle();
            m0_req = 1'b1; m0_addr = 32'h10; m1_req = 1'b1; m1_addr = 32'h20;
            mem_rdata = 32'h55;
`ifdef ARB_ROUND_ROBIN_EN
            exp_m1 = (i % 2 == 0);
`else
            exp_m1 = 1'b0;
`endif
            exp_m0 = !exp_m1;
            @(negedge clk);
            chk($sformatf("arb%0d m0_gnt", i), {31'b0, m0_gnt}, {31'b0, exp_m0});
            chk($sformatf("arb%0d m1_gnt", i), {31'b0, m1_gnt}, {31'b0, exp_m1});
            chk($sformatf("arb%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, prev_m0});
            chk($sformatf("arb%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, prev_m1});
            prev_m0 = exp_m0; prev_m1 = exp_m1;
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("arb tail m0_rvalid", {31'b0, m0_rvalid}, {31'b0, prev_m0});
        chk("arb tail m1_rvalid", {31'b0, m1_rvalid}, {31'b0, prev_m1});
        chk("arb tail rdata", prev_m0 ? m0_rdata : m1_rdata, 32'h55);

        // Reset lands in the cycle a read would have returned
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4; mem_rdata = 32'h77;
        @(negedge clk);
        chk("mid m0_gnt", {31'b0, m0_gnt}, 1);
        @(posedge clk); #1;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst m0_rvalid", {31'b0, m0_rvalid}, 0);
        chk("mid rst m0_rdata", m0_rdata, 0);
        chk("mid rst ledr", {22'b0, ledr_out}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("post rst%0d m0_rvalid", i), {31'b0, m0_rvalid}, 0);
            chk($sformatf("post rst%0d m1_rvalid", i), {31'b0, m1_rvalid}, 0);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
